pipe_int_sequencer: RTL and testbench

Interrupt sequencer for the 5-stage pipeline. It arbitrates NUM_IRQ level-sensitive interrupt sources and generates the single-cycle INT_detected/INT_restore controls that every stage register (IF_ID, ID_EX, EX_MEM, MEM_WB) uses to back up and restore its contents. It also redirects the PC to the handler vector and tracks handler residency until mret commits.

---
 rtl/pipe_int_pkg.sv | 23 ++
 rtl/pipe_int_sequencer_if.sv | 30 +++
 rtl/irq_prio_enc.sv | 21 ++
 rtl/pipe_int_sequencer.sv | 140 ++++++++++++++
 tb/tb_pipe_int_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_int_pkg.sv
// Shared types and constants for the pipeline interrupt sequencer.
package pipe_int_pkg;

  localparam int unsigned CAUSE_W = 3;
  localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_1000;
  localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'd16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE    = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    RESTORE = 3'd4
  } int_state_e;

  // Handler entry address; 32-bit wrap-around is intended.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [CAUSE_W-1:0] cause);
    return base + (32'(cause) * stride);
  endfunction

endpackage

// File: rtl/pipe_int_sequencer_if.sv
// Interrupt request / pipeline control bundle between the pipeline and the sequencer.
interface pipe_int_sequencer_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_mask_i;
  logic               int_en_i;
  logic               pipe_stall_i;
  logic               mret_i;
  logic               int_detected_o;
  logic               int_restore_o;
  logic               vec_valid_o;
  logic [31:0]        vec_pc_o;
  logic [NUM_IRQ-1:0] irq_ack_o;
  logic [2:0]         int_cause_o;
  logic               int_active_o;
  logic               int_timeout_o;

  modport master (
    output irq_i, irq_mask_i, int_en_i, pipe_stall_i, mret_i,
    input  int_detected_o, int_restore_o, vec_valid_o, vec_pc_o,
           irq_ack_o, int_cause_o, int_active_o, int_timeout_o
  );

  modport slave (
    input  irq_i, irq_mask_i, int_en_i, pipe_stall_i, mret_i,
    output int_detected_o, int_restore_o, vec_valid_o, vec_pc_o,
           irq_ack_o, int_cause_o, int_active_o, int_timeout_o
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: bit 0 wins, idx is the lowest set request index.
module irq_prio_enc
  import pipe_int_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [CAUSE_W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) idx = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/pipe_int_sequencer.sv
// Interrupt sequencer: IDLE -> SAVE -> VECTOR -> HANDLER -> RESTORE.
// Optional handler watchdog enabled by defining INT_TIMEOUT_EN.
module pipe_int_sequencer
  import pipe_int_pkg::*;
#(
  parameter int unsigned NUM_IRQ        = 4,
  parameter logic [31:0] VEC_BASE       = VEC_BASE_DEFAULT,
  parameter logic [31:0] VEC_STRIDE     = VEC_STRIDE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  pipe_int_sequencer_if.slave bus
);

  if (NUM_IRQ < 1 || NUM_IRQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("pipe_int_sequencer: unsupported NUM_IRQ or TIMEOUT_CYCLES");
  end

  int_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] req_c;
  logic               req_valid_c;
  logic [CAUSE_W-1:0] req_idx_c;

  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [31:0]        vec_pc_q, vec_pc_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic               det_q, det_d;
  logic               restore_q, restore_d;
  logic               vec_valid_q, vec_valid_d;
  logic               active_q, active_d;
`ifdef INT_TIMEOUT_EN
  logic [31:0]        wd_cnt_q, wd_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  assign req_c = bus.irq_i & bus.irq_mask_i;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req   (req_c),
    .valid (req_valid_c),
    .idx   (req_idx_c)
  );

  // Next state plus the registered outputs that the next state implies.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    vec_pc_d = vec_pc_q;
`ifdef INT_TIMEOUT_EN
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.int_en_i && req_valid_c && !bus.pipe_stall_i) begin
          state_d  = SAVE;
          cause_d  = req_idx_c;
          vec_pc_d = vec_addr(VEC_BASE, VEC_STRIDE, req_idx_c);
        end
      end
      SAVE:   state_d = VECTOR;
      VECTOR: begin
        state_d = HANDLER;
`ifdef INT_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      HANDLER: begin
        if (bus.mret_i) begin
          state_d = RESTORE;
        end
`ifdef INT_TIMEOUT_EN
        // mret on the limit cycle wins and leaves the watchdog flag clear.
        else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d   = RESTORE;
          timeout_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
`endif
      end
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    det_d       = (state_d == SAVE);
    vec_valid_d = (state_d == VECTOR);
    restore_d   = (state_d == RESTORE);
    active_d    = (state_d != IDLE);
    ack_d       = (state_d == SAVE) ? (NUM_IRQ'(1) << cause_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cause_q     <= '0;
      vec_pc_q    <= '0;
      ack_q       <= '0;
      det_q       <= 1'b0;
      restore_q   <= 1'b0;
      vec_valid_q <= 1'b0;
      active_q    <= 1'b0;
`ifdef INT_TIMEOUT_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      vec_pc_q    <= vec_pc_d;
      ack_q       <= ack_d;
      det_q       <= det_d;
      restore_q   <= restore_d;
      vec_valid_q <= vec_valid_d;
      active_q    <= active_d;
`ifdef INT_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.int_detected_o = det_q;
  assign bus.int_restore_o  = restore_q;
  assign bus.vec_valid_o    = vec_valid_q;
  assign bus.vec_pc_o       = vec_pc_q;
  assign bus.irq_ack_o      = ack_q;
  assign bus.int_cause_o    = cause_q;
  assign bus.int_active_o   = active_q;
`ifdef INT_TIMEOUT_EN
  assign bus.int_timeout_o  = timeout_q;
`else
  assign bus.int_timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_int_sequencer.sv
// Self-checking bench for pipe_int_sequencer (directed scenarios plus randomized entries).
module tb_pipe_int_sequencer;

  localparam int unsigned N  = 4;
  localparam logic [31:0] VB = 32'h0000_1000;
  localparam logic [31:0] VS = 32'd16;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_int_sequencer_if #(.NUM_IRQ(N)) bus ();

  pipe_int_sequencer #(
    .NUM_IRQ        (N),
    .VEC_BASE       (VB),
    .VEC_STRIDE     (VS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [N-1:0] r);
    for (int i = 0; i < int'(N); i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_vec(input int c);
    return VB + VS * 32'(c);
  endfunction

  task automatic idle_inputs();
    bus.irq_i        = '0;
    bus.irq_mask_i   = '1;
    bus.int_en_i     = 1'b1;
    bus.pipe_stall_i = 1'b0;
    bus.mret_i       = 1'b0;
  endtask

  // Walks any in-progress sequence back to idle by issuing mret in the handler.
  task automatic drain();
    int n = 0;
    bus.irq_i = '0;
    while (bus.int_active_o === 1'b1 && n < 20) begin
      bus.mret_i = (bus.int_detected_o !== 1'b1 && bus.vec_valid_o !== 1'b1 &&
                    bus.int_restore_o !== 1'b1);
      tick();
      bus.mret_i = 1'b0;
      n++;
    end
    checks++;
    if (bus.int_active_o !== 1'b0) begin
      errors++;
      $display("FAIL drain: int_active_o=%0b want 0 after %0d cycles", bus.int_active_o, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.int_detected_o, bus.int_restore_o, bus.vec_valid_o, bus.int_active_o,
         bus.int_timeout_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {bus.int_detected_o, bus.int_restore_o,
               bus.vec_valid_o, bus.int_active_o, bus.int_timeout_o});
    end
    checks++;
    if (bus.vec_pc_o !== 32'h0 || bus.int_cause_o !== 3'd0 || bus.irq_ack_o !== '0) begin
      errors++;
      $display("FAIL reset_values: vec=%h cause=%0d ack=%b want 0", bus.vec_pc_o,
               bus.int_cause_o, bus.irq_ack_o);
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_entry(input string name, input logic [N-1:0] pat,
                            input logic [N-1:0] want_ack, input logic [2:0] want_cause,
                            input logic [31:0] want_vec);
    bus.irq_i = pat;
    tick();
    bus.irq_i = '0;
    checks++;
    if (bus.int_detected_o !== 1'b1 || bus.irq_ack_o !== want_ack || bus.int_cause_o !== want_cause) begin
      errors++;
      $display("FAIL %s_save: det=%0b ack=%b cause=%0d want 1 %b %0d", name, bus.int_detected_o,
               bus.irq_ack_o, bus.int_cause_o, want_ack, want_cause);
    end
    tick();
    checks++;
    if (bus.vec_valid_o !== 1'b1 || bus.vec_pc_o !== want_vec || bus.int_detected_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_vector: vv=%0b pc=%h det=%0b want 1 %h 0", name, bus.vec_valid_o,
               bus.vec_pc_o, bus.int_detected_o, want_vec);
    end
    tick();
    checks++;
    if (bus.int_active_o !== 1'b1 || bus.vec_valid_o !== 1'b0 || bus.irq_ack_o !== '0) begin
      errors++;
      $display("FAIL %s_handler: act=%0b vv=%0b ack=%b want 1 0 0", name, bus.int_active_o,
               bus.vec_valid_o, bus.irq_ack_o);
    end
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    checks++;
    if (bus.int_restore_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_restore: int_restore_o=%0b want 1", name, bus.int_restore_o);
    end
    tick();
    checks++;
    if (bus.int_active_o !== 1'b0 || bus.int_restore_o !== 1'b0 || bus.int_cause_o !== want_cause) begin
      errors++;
      $display("FAIL %s_idle: act=%0b rst=%0b cause=%0d want 0 0 %0d", name, bus.int_active_o,
               bus.int_restore_o, bus.int_cause_o, want_cause);
    end
  endtask

  task automatic test_stall();
    bus.irq_i        = 4'b0001;
    bus.pipe_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.int_detected_o !== 1'b0 || bus.int_active_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: det=%0b act=%0b want 0 0", i, bus.int_detected_o,
                 bus.int_active_o);
      end
    end
    bus.pipe_stall_i = 1'b0;
    tick();
    checks++;
    if (bus.int_detected_o !== 1'b1 || bus.int_cause_o !== 3'd0) begin
      errors++;
      $display("FAIL stall_release: det=%0b cause=%0d want 1 0", bus.int_detected_o, bus.int_cause_o);
    end
    drain();
  endtask

  task automatic test_no_nesting();
    bus.irq_i = 4'b0100;
    tick();
    bus.irq_i = '0;
    tick();
    tick();
    bus.irq_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.int_detected_o !== 1'b0 || bus.int_active_o !== 1'b1 || bus.int_cause_o !== 3'd2) begin
        errors++;
        $display("FAIL nest_ignore%0d: det=%0b act=%0b cause=%0d want 0 1 2", i,
                 bus.int_detected_o, bus.int_active_o, bus.int_cause_o);
      end
    end
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    checks++;
    if (bus.int_restore_o !== 1'b1) begin
      errors++;
      $display("FAIL nest_restore: int_restore_o=%0b want 1", bus.int_restore_o);
    end
    tick();
    checks++;
    if (bus.int_detected_o !== 1'b0 || bus.int_active_o !== 1'b0) begin
      errors++;
      $display("FAIL nest_gap: det=%0b act=%0b want 0 0", bus.int_detected_o, bus.int_active_o);
    end
    tick();
    checks++;
    if (bus.int_detected_o !== 1'b1 || bus.int_cause_o !== 3'd0 || bus.irq_ack_o !== 4'b0001) begin
      errors++;
      $display("FAIL nest_reentry: det=%0b cause=%0d ack=%b want 1 0 0001", bus.int_detected_o,
               bus.int_cause_o, bus.irq_ack_o);
    end
    drain();
  endtask

  task automatic test_mret_idle();
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    checks++;
    if (bus.int_restore_o !== 1'b0 || bus.int_active_o !== 1'b0) begin
      errors++;
      $display("FAIL mret_idle: rst=%0b act=%0b want 0 0", bus.int_restore_o, bus.int_active_o);
    end
    tick();
    checks++;
    if (bus.int_restore_o !== 1'b0) begin
      errors++;
      $display("FAIL mret_idle_late: int_restore_o=%0b want 0", bus.int_restore_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.irq_i = 4'b0010;
    tick();
    bus.irq_i = '0;
    tick();
    checks++;
    if (bus.vec_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rmid_vector: vec_valid_o=%0b want 1", bus.vec_valid_o);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.int_detected_o, bus.int_restore_o, bus.vec_valid_o, bus.int_active_o} !== 4'b0 ||
        bus.vec_pc_o !== 32'h0 || bus.int_cause_o !== 3'd0 || bus.irq_ack_o !== '0) begin
      errors++;
      $display("FAIL rmid_async: flags=%b pc=%h cause=%0d ack=%b want all 0",
               {bus.int_detected_o, bus.int_restore_o, bus.vec_valid_o, bus.int_active_o},
               bus.vec_pc_o, bus.int_cause_o, bus.irq_ack_o);
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.int_restore_o !== 1'b0 || bus.int_active_o !== 1'b0) begin
        errors++;
        $display("FAIL rmid_after%0d: rst=%0b act=%0b want 0 0", i, bus.int_restore_o,
                 bus.int_active_o);
      end
    end
  endtask

  // Each iteration starts in idle; expectation follows from the qualification rule.
  task automatic test_random();
    logic [N-1:0] r, m, q, want_ack;
    logic         en, st;
    int           c, hlen;
    for (int it = 0; it < 60; it++) begin
      r  = N'($urandom);
      m  = N'($urandom);
      en = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      bus.irq_i = r; bus.irq_mask_i = m; bus.int_en_i = en; bus.pipe_stall_i = st;
      q = r & m;
      tick();
      bus.irq_i = '0; bus.pipe_stall_i = 1'b0;
      if (en && q != '0 && !st) begin
        c = lowest(q);
        want_ack = '0;
        want_ack[c] = 1'b1;
        checks++;
        if (bus.int_detected_o !== 1'b1 || bus.irq_ack_o !== want_ack || bus.int_cause_o !== 3'(c)) begin
          errors++;
          $display("FAIL rnd%0d_save: det=%0b ack=%b cause=%0d want 1 %b %0d", it,
                   bus.int_detected_o, bus.irq_ack_o, bus.int_cause_o, want_ack, c);
        end
        tick();
        checks++;
        if (bus.vec_valid_o !== 1'b1 || bus.vec_pc_o !== exp_vec(c)) begin
          errors++;
          $display("FAIL rnd%0d_vec: vv=%0b pc=%h want 1 %h", it, bus.vec_valid_o,
                   bus.vec_pc_o, exp_vec(c));
        end
        tick();
        hlen = $urandom_range(0, 5);
        for (int h = 0; h < hlen; h++) begin
          bus.irq_i = N'($urandom); bus.irq_mask_i = N'($urandom); bus.int_en_i = $urandom_range(0, 1) == 1;
          tick();
          checks++;
          if ({bus.int_detected_o, bus.vec_valid_o, bus.int_restore_o, bus.int_active_o} !== 4'b0001 ||
              bus.int_cause_o !== 3'(c)) begin
            errors++;
            $display("FAIL rnd%0d_hold%0d: det/vv/rst/act=%b cause=%0d want 0001 %0d", it, h,
                     {bus.int_detected_o, bus.vec_valid_o, bus.int_restore_o, bus.int_active_o},
                     bus.int_cause_o, c);
          end
        end
        bus.irq_i = '0;
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        checks++;
        if (bus.int_restore_o !== 1'b1) begin
          errors++;
          $display("FAIL rnd%0d_restore: int_restore_o=%0b want 1", it, bus.int_restore_o);
        end
        tick();
      end else begin
        checks++;
        if (bus.int_detected_o !== 1'b0 || bus.int_active_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_noentry: det=%0b act=%0b want 0 0", it, bus.int_detected_o,
                   bus.int_active_o);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int n;
    bus.irq_i = 4'b1000;
    tick(); bus.irq_i = '0; tick(); tick();
`ifdef INT_TIMEOUT_EN
    repeat (7) tick();
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    checks++;
    if (bus.int_restore_o !== 1'b1 || bus.int_timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL to_mret_wins: rst=%0b to=%0b want 1 0", bus.int_restore_o, bus.int_timeout_o);
    end
    tick();
    bus.irq_i = 4'b1000;
    tick(); bus.irq_i = '0; tick(); tick();
    n = 0;
    while (bus.int_restore_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != int'(TO)) begin
      errors++;
      $display("FAIL to_latency: restore after %0d cycles want %0d", n, TO);
    end
    checks++;
    if (bus.int_timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL to_flag: int_timeout_o=%0b want 1", bus.int_timeout_o);
    end
    bus.irq_i = 4'b0001;
    tick(); tick();
    drain();
    checks++;
    if (bus.int_timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: int_timeout_o=%0b want 1", bus.int_timeout_o);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (bus.int_timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: int_timeout_o=%0b want 0", bus.int_timeout_o);
    end
    reset = 1'b0;
    tick();
`else
    n = 0;
    repeat (20) begin
      tick();
      if (bus.int_restore_o === 1'b1) n++;
    end
    checks++;
    if (n != 0 || bus.int_active_o !== 1'b1 || bus.int_timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog: restores=%0d act=%0b to=%0b want 0 1 0", n,
               bus.int_active_o, bus.int_timeout_o);
    end
    drain();
`endif
  endtask

  initial begin
    test_reset();
    test_entry("single", 4'b0100, 4'b0100, 3'd2, 32'h0000_1020);
    test_entry("prio", 4'b1010, 4'b0010, 3'd1, 32'h0000_1010);
    test_stall();
    test_no_nesting();
    test_mret_idle();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "timeout");
  end

endmodule
